// File: rtl/hp_if.sv
// Handshake and status bundle between the HP controller and its neighbours.
// The neighbours are the collision logic, the UART link and the HUD overlay.
interface hp_if;
  logic       game_start;
  logic       hit_us;
  logic [7:0] enemy_hp_in;
  logic       enemy_hp_valid;
  logic       hp_tx_ready;
  logic [7:0] HP_our_state;
  logic [7:0] HP_enemy_state;
  logic [7:0] hp_tx_data;
  logic       hp_tx_valid;
  logic       invuln;
  logic       round_over;

  modport master (
    output game_start, hit_us, enemy_hp_in, enemy_hp_valid, hp_tx_ready,
    input  HP_our_state, HP_enemy_state, hp_tx_data, hp_tx_valid, invuln, round_over
  );

  modport slave (
    input  game_start, hit_us, enemy_hp_in, enemy_hp_valid, hp_tx_ready,
    output HP_our_state, HP_enemy_state, hp_tx_data, hp_tx_valid, invuln, round_over
  );
endinterface

// File: rtl/hp_controller.sv
// Own/enemy HP bookkeeping with a post-hit invulnerability window.
// Our HP is streamed to the link transmitter over valid/ready.
module hp_controller #(
  parameter int HP_MAX        = 200,
  parameter int DMG_HIT       = 20,
  parameter int INVULN_CYCLES = 20_000_000
) (
  input logic clk,
  input logic rst,
  hp_if.slave bus
);
  localparam int               CNT_W    = $clog2(INVULN_CYCLES + 1);
  localparam logic [7:0]       HP_FULL  = 8'(HP_MAX);
  localparam logic [7:0]       DMG      = 8'(DMG_HIT);
  localparam logic [CNT_W-1:0] INV_LOAD = CNT_W'(INVULN_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t           state_q, state_d;
  logic [7:0]       hp_our_q, hp_our_d;
  logic [7:0]       hp_enemy_q, hp_enemy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic             invuln_q, invuln_d;
  logic             tx_pending_q, tx_pending_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             round_over_q, round_over_d;
  logic             set_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hp_our_q     <= HP_FULL;
      hp_enemy_q   <= HP_FULL;
      cnt_q        <= '0;
      invuln_q     <= 1'b0;
      tx_pending_q <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'd0;
      round_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hp_our_q     <= hp_our_d;
      hp_enemy_q   <= hp_enemy_d;
      cnt_q        <= cnt_d;
      invuln_q     <= invuln_d;
      tx_pending_q <= tx_pending_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      round_over_q <= round_over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.game_start) begin
      state_d = S_PLAY;
    end else if (state_q == S_PLAY && (hp_our_d == 8'd0 || hp_enemy_d == 8'd0)) begin
      state_d = S_OVER;
    end
  end

  // A hit is accepted once the window would expire on this very edge, so a
  // hit exactly INVULN_CYCLES edges after the previous one still lands.
  always_comb begin
    cnt_dec     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    cnt_d       = cnt_dec;
    hp_our_d    = hp_our_q;
    hp_enemy_d  = hp_enemy_q;
    set_pending = 1'b0;
    if (bus.game_start) begin
      hp_our_d    = HP_FULL;
      hp_enemy_d  = HP_FULL;
      cnt_d       = '0;
      set_pending = 1'b1;
    end else if (state_q == S_PLAY) begin
      if (bus.hit_us && cnt_dec == '0) begin
        hp_our_d    = (hp_our_q > DMG) ? hp_our_q - DMG : 8'd0;
        cnt_d       = INV_LOAD;
        set_pending = 1'b1;
      end
      if (bus.enemy_hp_valid) begin
        hp_enemy_d = (bus.enemy_hp_in > HP_FULL) ? HP_FULL : bus.enemy_hp_in;
      end
    end
  end

  always_comb begin
    invuln_d     = (cnt_d != '0);
    round_over_d = (state_d == S_OVER);
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    tx_pending_d = tx_pending_q | set_pending;
    if (tx_valid_q && bus.hp_tx_ready) begin
      tx_valid_d = 1'b0;
    end else if (!tx_valid_q && tx_pending_q) begin
      tx_valid_d   = 1'b1;
      tx_data_d    = hp_our_d;
      tx_pending_d = 1'b0;
    end
  end

  assign bus.HP_our_state   = hp_our_q;
  assign bus.HP_enemy_state = hp_enemy_q;
  assign bus.hp_tx_data     = tx_data_q;
  assign bus.hp_tx_valid    = tx_valid_q;
  assign bus.invuln         = invuln_q;
  assign bus.round_over     = round_over_q;
endmodule

// File: tb/tb_hp_controller.sv
// Bench for hp_controller with a short invulnerability window.
// Expected TX bytes are queued as stimulus is driven and popped on each handshake.
module tb_hp_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] exp_tx_q[$];

  hp_if bus_if();

  hp_controller #(.HP_MAX(200), .DMG_HIT(20), .INVULN_CYCLES(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Handshake monitor: valid & ready seen mid-cycle completes on the next edge.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (!rst && bus_if.hp_tx_valid === 1'b1 && bus_if.hp_tx_ready === 1'b1) begin
      checks++;
      if (exp_tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected got %0d want none", bus_if.hp_tx_data);
      end else begin
        exp_b = exp_tx_q.pop_front();
        if (bus_if.hp_tx_data !== exp_b) begin
          errors++;
          $display("FAIL tx_data got %0d want %0d", bus_if.hp_tx_data, exp_b);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    bus_if.game_start = 0; bus_if.hit_us = 0; bus_if.enemy_hp_in = 0;
    bus_if.enemy_hp_valid = 0; bus_if.hp_tx_ready = 1;
    rst = 1;
    step(); step();
    rst = 0;
    chk("rst_hp_our", bus_if.HP_our_state, 8'd200);
    chk("rst_hp_enemy", bus_if.HP_enemy_state, 8'd200);
    chk("rst_tx_valid", 8'(bus_if.hp_tx_valid), 8'd0);
    chk("rst_tx_data", bus_if.hp_tx_data, 8'd0);
    chk("rst_invuln", 8'(bus_if.invuln), 8'd0);
    chk("rst_round_over", 8'(bus_if.round_over), 8'd0);
    bus_if.hit_us = 1;
    step();
    bus_if.hit_us = 0;
    chk("idle_hit_hp", bus_if.HP_our_state, 8'd200);
    chk("idle_hit_invuln", 8'(bus_if.invuln), 8'd0);
    step();
    chk("idle_hit_no_tx", 8'(bus_if.hp_tx_valid), 8'd0);
  endtask

  task automatic test_start();
    bus_if.game_start = 1;
    exp_tx_q.push_back(8'd200);
    step();
    bus_if.game_start = 0;
    chk("start_hp_our", bus_if.HP_our_state, 8'd200);
    chk("start_hp_enemy", bus_if.HP_enemy_state, 8'd200);
    chk("start_valid_lat", 8'(bus_if.hp_tx_valid), 8'd0);
    step();
    chk("start_valid", 8'(bus_if.hp_tx_valid), 8'd1);
    chk("start_data", bus_if.hp_tx_data, 8'd200);
    step();
    chk("start_valid_drop", 8'(bus_if.hp_tx_valid), 8'd0);
  endtask

  task automatic test_invuln();
    bus_if.hit_us = 1;
    exp_tx_q.push_back(8'd180);
    step();
    bus_if.hit_us = 0;
    chk("inv_hit0_hp", bus_if.HP_our_state, 8'd180);
    chk("inv_hit0_flag", 8'(bus_if.invuln), 8'd1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("inv_window", 8'(bus_if.invuln), 8'd1);
    end
    bus_if.hit_us = 1;
    step();
    bus_if.hit_us = 0;
    chk("inv_hit4_ignored", bus_if.HP_our_state, 8'd180);
    for (int i = 5; i <= 7; i++) begin
      step();
      chk("inv_window_late", 8'(bus_if.invuln), 8'd1);
    end
    bus_if.hit_us = 1;
    exp_tx_q.push_back(8'd160);
    step();
    bus_if.hit_us = 0;
    chk("inv_hit8_hp", bus_if.HP_our_state, 8'd160);
    for (int i = 9; i <= 15; i++) step();
    chk("inv_last_cycle", 8'(bus_if.invuln), 8'd1);
    step();
    chk("inv_expired", 8'(bus_if.invuln), 8'd0);
  endtask

  task automatic test_hits_to_zero();
    logic [7:0] want;
    bus_if.game_start = 1;
    exp_tx_q.push_back(8'd200);
    step();
    bus_if.game_start = 0;
    step(); step();
    want = 8'd200;
    for (int i = 0; i < 10; i++) begin
      want = want - 8'd20;
      exp_tx_q.push_back(want);
      bus_if.hit_us = 1;
      step();
      bus_if.hit_us = 0;
      chk("zero_step_hp", bus_if.HP_our_state, want);
      chk("zero_round_over", 8'(bus_if.round_over), (i == 9) ? 8'd1 : 8'd0);
      for (int j = 0; j < 8; j++) step();
    end
    bus_if.hit_us = 1; bus_if.enemy_hp_valid = 1; bus_if.enemy_hp_in = 8'd50;
    step();
    bus_if.hit_us = 0; bus_if.enemy_hp_valid = 0;
    chk("over_hp_frozen", bus_if.HP_our_state, 8'd0);
    chk("over_enemy_frozen", bus_if.HP_enemy_state, 8'd200);
    chk("over_still", 8'(bus_if.round_over), 8'd1);
    step(); step();
    chk("over_no_tx", 8'(bus_if.hp_tx_valid), 8'd0);
  endtask

  task automatic test_enemy();
    bus_if.game_start = 1;
    exp_tx_q.push_back(8'd200);
    step();
    bus_if.game_start = 0;
    chk("restart_hp_our", bus_if.HP_our_state, 8'd200);
    chk("restart_round_over", 8'(bus_if.round_over), 8'd0);
    step(); step();
    bus_if.enemy_hp_valid = 1; bus_if.enemy_hp_in = 8'd250;
    step();
    chk("enemy_clamp", bus_if.HP_enemy_state, 8'd200);
    bus_if.enemy_hp_in = 8'd123;
    step();
    chk("enemy_value", bus_if.HP_enemy_state, 8'd123);
    bus_if.enemy_hp_in = 8'd100; bus_if.hit_us = 1;
    exp_tx_q.push_back(8'd180);
    step();
    bus_if.hit_us = 0; bus_if.enemy_hp_valid = 0;
    chk("combo_hp_our", bus_if.HP_our_state, 8'd180);
    chk("combo_hp_enemy", bus_if.HP_enemy_state, 8'd100);
    step(); step();
    bus_if.enemy_hp_valid = 1; bus_if.enemy_hp_in = 8'd0;
    step();
    bus_if.enemy_hp_valid = 0;
    chk("enemy_zero_hp", bus_if.HP_enemy_state, 8'd0);
    chk("enemy_zero_over", 8'(bus_if.round_over), 8'd1);
    bus_if.game_start = 1;
    exp_tx_q.push_back(8'd200);
    step();
    bus_if.game_start = 0;
    chk("over_restart_our", bus_if.HP_our_state, 8'd200);
    chk("over_restart_enemy", bus_if.HP_enemy_state, 8'd200);
    chk("over_restart_play", 8'(bus_if.round_over), 8'd0);
    chk("over_restart_invuln", 8'(bus_if.invuln), 8'd0);
    step(); step();
  endtask

  task automatic test_backpressure();
    bus_if.hp_tx_ready = 0;
    bus_if.game_start = 1;
    exp_tx_q.push_back(8'd200);
    step();
    bus_if.game_start = 0;
    step();
    chk("bp_valid", 8'(bus_if.hp_tx_valid), 8'd1);
    chk("bp_data", bus_if.hp_tx_data, 8'd200);
    bus_if.hit_us = 1;
    step();
    bus_if.hit_us = 0;
    chk("bp_hit1_hp", bus_if.HP_our_state, 8'd180);
    chk("bp_hit1_data", bus_if.hp_tx_data, 8'd200);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("bp_hold_valid", 8'(bus_if.hp_tx_valid), 8'd1);
      chk("bp_hold_data", bus_if.hp_tx_data, 8'd200);
    end
    bus_if.hit_us = 1;
    step();
    bus_if.hit_us = 0;
    chk("bp_hit2_hp", bus_if.HP_our_state, 8'd160);
    chk("bp_hit2_data", bus_if.hp_tx_data, 8'd200);
    exp_tx_q.push_back(8'd160);
    bus_if.hp_tx_ready = 1;
    step();
    chk("bp_accept_drop", 8'(bus_if.hp_tx_valid), 8'd0);
    step();
    chk("bp_reraise", 8'(bus_if.hp_tx_valid), 8'd1);
    chk("bp_fresh_data", bus_if.hp_tx_data, 8'd160);
    step();
    chk("bp_final_drop", 8'(bus_if.hp_tx_valid), 8'd0);
  endtask

  task automatic test_reset_mid();
    bus_if.hp_tx_ready = 0;
    bus_if.game_start = 1;
    step();
    bus_if.game_start = 0;
    bus_if.hit_us = 1;
    step();
    bus_if.hit_us = 0;
    chk("mid_valid", 8'(bus_if.hp_tx_valid), 8'd1);
    chk("mid_data_same_edge", bus_if.hp_tx_data, 8'd180);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_valid", 8'(bus_if.hp_tx_valid), 8'd0);
    chk("mid_rst_data", bus_if.hp_tx_data, 8'd0);
    chk("mid_rst_hp_our", bus_if.HP_our_state, 8'd200);
    chk("mid_rst_invuln", 8'(bus_if.invuln), 8'd0);
    chk("mid_rst_round_over", 8'(bus_if.round_over), 8'd0);
    bus_if.hit_us = 1;
    step();
    bus_if.hit_us = 0;
    chk("mid_idle_hit_hp", bus_if.HP_our_state, 8'd200);
    chk("mid_idle_hit_invuln", 8'(bus_if.invuln), 8'd0);
    bus_if.hp_tx_ready = 1;
    step(); step();
    chk("mid_idle_no_tx", 8'(bus_if.hp_tx_valid), 8'd0);
  endtask

  initial begin
    test_reset();
    test_start();
    test_invuln();
    test_hits_to_zero();
    test_enemy();
    test_backpressure();
    test_reset_mid();
    checks++;
    if (exp_tx_q.size() != 0) begin
      errors++;
      $display("FAIL tx_queue_drained got %0d left want 0", exp_tx_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
